// File: rtl/mem_channel_arbiter_pkg.sv
// Shared types for the memory channel arbiter: per-channel FSM states and index sizing.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    WR_WAIT  = 3'd4,
    RELAY    = 3'd5
  } chan_state_t;

  // Index width that stays legal (>= 1 bit) when only one requester exists.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_channel_arbiter_if.sv
// Consumer-side level handshakes plus memory-side pulse handshakes of the arbiter.
// master = arbiter view, slave = consumers + memory model view.
interface mem_channel_arbiter_if #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 2
);
  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0] consumer_read_addr;
  logic [NUM_CONSUMERS-1:0]                 consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0] consumer_write_addr;
  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                 consumer_write_ready;
  logic [NUM_CHANNELS-1:0]                  mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  mem_read_addr;
  logic [NUM_CHANNELS-1:0]                  mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  mem_read_data;
  logic [NUM_CHANNELS-1:0]                  mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  mem_write_addr;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  mem_write_data;
  logic [NUM_CHANNELS-1:0]                  mem_write_ready;

  modport master (
    input  consumer_read_valid, consumer_read_addr,
    input  consumer_write_valid, consumer_write_addr, consumer_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output mem_read_valid, mem_read_addr, mem_write_valid, mem_write_addr, mem_write_data
  );

  modport slave (
    output consumer_read_valid, consumer_read_addr,
    output consumer_write_valid, consumer_write_addr, consumer_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  mem_read_valid, mem_read_addr, mem_write_valid, mem_write_addr, mem_write_data
  );
endinterface

// File: rtl/mem_channel_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// The pointer register lives in the parent.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);
  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!grant_vld && req[idx]) begin
        grant_vld      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/mem_channel_arbiter.sv
// Shares NUM_CHANNELS memory ports among NUM_CONSUMERS requesters; one grant per cycle
// to the lowest idle channel, one-cycle memory issue pulses, level handshake back to the owner.
module mem_channel_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 2,
  parameter int WRITE_ENABLE  = 1
) (
  input logic            clk,
  input logic            reset,
  mem_channel_arbiter_if.master bus
);
  localparam int CW = idx_width(NUM_CONSUMERS);

  logic [NUM_CONSUMERS-1:0] busy_q, rd_v, wr_v, elig, grant_oh, release_mask;
  logic [NUM_CONSUMERS-1:0] crr, cwr;
  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] crd;
  logic [CW-1:0]            rr_ptr_q, grant_idx;
  logic                     grant_vld, any_idle, do_grant;
  logic [NUM_CHANNELS-1:0]  ch_idle, ch_grant, ch_relay_rd, ch_relay_wr, ch_release;
  logic [CW-1:0]            ch_owner [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]    ch_rdata [NUM_CHANNELS];

  assign rd_v = bus.consumer_read_valid;
  assign wr_v = (WRITE_ENABLE != 0) ? bus.consumer_write_valid : '0;
  assign elig = (rd_v | wr_v) & ~busy_q;

  rr_arbiter #(.N(NUM_CONSUMERS), .IW(CW)) u_rr (
    .req       (elig),
    .ptr       (rr_ptr_q),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    ch_grant = '0;
    any_idle = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!any_idle && ch_idle[c]) begin
        any_idle    = 1'b1;
        ch_grant[c] = grant_vld;
      end
    end
  end
  assign do_grant = grant_vld & any_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      busy_q <= (busy_q | (do_grant ? grant_oh : '0)) & ~release_mask;
      if (do_grant)
        rr_ptr_q <= (grant_idx == CW'(NUM_CONSUMERS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Fan channel relay status back out to the owning consumer.
  always_comb begin
    release_mask = '0;
    crr          = '0;
    cwr          = '0;
    crd          = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
        if (ch_owner[c] == CW'(k)) begin
          if (ch_release[c]) release_mask[k] = 1'b1;
          if (ch_relay_wr[c]) cwr[k] = 1'b1;
          if (ch_relay_rd[c]) begin
            crr[k] = 1'b1;
            crd[k] = ch_rdata[c];
          end
        end
      end
    end
  end
  assign bus.consumer_read_ready  = crr;
  assign bus.consumer_read_data   = crd;
  assign bus.consumer_write_ready = cwr;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    chan_state_t           state_q, state_d;
    logic [CW-1:0]         owner_q;
    logic                  rd_op_q, take, rd_sel, owner_vld;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic                  is_idle, relay_rd, relay_wr, rel, mrv, mwv;

    assign take      = ch_grant[c];
    assign rd_sel    = rd_v[grant_idx];
    assign owner_vld = rd_op_q ? rd_v[owner_q] : wr_v[owner_q];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:     if (take) state_d = rd_sel ? RD_ISSUE : WR_ISSUE;
        RD_ISSUE: state_d = RD_WAIT;
        RD_WAIT:  if (bus.mem_read_ready[c]) state_d = RELAY;
        WR_ISSUE: state_d = WR_WAIT;
        WR_WAIT:  if (bus.mem_write_ready[c]) state_d = RELAY;
        RELAY:    if (!owner_vld) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end

    always_comb begin
      is_idle  = 1'b0;
      relay_rd = 1'b0;
      relay_wr = 1'b0;
      rel      = 1'b0;
      mrv      = 1'b0;
      mwv      = 1'b0;
      case (state_q)
        IDLE:     is_idle = 1'b1;
        RD_ISSUE: mrv = 1'b1;
        WR_ISSUE: mwv = (WRITE_ENABLE != 0);
        RELAY: begin
          relay_rd = rd_op_q;
          relay_wr = !rd_op_q;
          rel      = !owner_vld;
        end
        default: ;
      endcase
    end

    // Request fields are captured at grant so memory sees them stable through WAIT.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        owner_q <= '0;
        rd_op_q <= 1'b0;
        addr_q  <= '0;
        wdata_q <= '0;
        rdata_q <= '0;
      end else begin
        if (take) begin
          owner_q <= grant_idx;
          rd_op_q <= rd_sel;
          addr_q  <= rd_sel ? bus.consumer_read_addr[grant_idx] : bus.consumer_write_addr[grant_idx];
          wdata_q <= rd_sel ? '0 : bus.consumer_write_data[grant_idx];
        end
        if (state_q == RD_WAIT && bus.mem_read_ready[c])
          rdata_q <= bus.mem_read_data[c];
      end
    end

    assign ch_idle[c]     = is_idle;
    assign ch_relay_rd[c] = relay_rd;
    assign ch_relay_wr[c] = relay_wr;
    assign ch_release[c]  = rel;
    assign ch_owner[c]    = owner_q;
    assign ch_rdata[c]    = rdata_q;

    assign bus.mem_read_valid[c]  = mrv;
    assign bus.mem_read_addr[c]   = addr_q;
    assign bus.mem_write_valid[c] = mwv;
    assign bus.mem_write_addr[c]  = (WRITE_ENABLE != 0) ? addr_q : '0;
    assign bus.mem_write_data[c]  = (WRITE_ENABLE != 0) ? wdata_q : '0;
  end
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Bench for mem_channel_arbiter: directed consumer traffic against a behavioural memory,
// expected completions queued at issue and matched by an independent monitor.
module tb_mem_channel_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_channel_arbiter_if bus ();
  mem_channel_arbiter_if bus2 ();

  mem_channel_arbiter #(.WRITE_ENABLE(1)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  mem_channel_arbiter #(.WRITE_ENABLE(0)) dut_nw (.clk(clk), .reset(reset), .bus(bus2.master));

  typedef struct { int k; logic [7:0] d; } exp_t;
  exp_t rd_exp[$];
  int   wr_exp[$];

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [256];
  int mem_lat = 2;
  int rd_cnt [2], wr_cnt [2];
  logic [7:0] rd_addr_p [2], wr_addr_p [2], wr_data_p [2];
  int rd_pulses = 0, wr_pulses = 0;
  int last_rd_issue_cyc [2];
  int rd_rise_cyc [4], wr_rise_cyc [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_rd(input int k, input logic [7:0] d);
    exp_t e;
    e.k = k;
    e.d = d;
    rd_exp.push_back(e);
  endtask

  // Behavioural memory: one-cycle ready pulse mem_lat cycles after each issue pulse.
  initial begin
    bus.mem_read_ready = '0;  bus.mem_read_data = '0;  bus.mem_write_ready = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_read_ready  = '0;
      bus.mem_write_ready = '0;
      if (reset) begin
        for (int c = 0; c < 2; c++) begin rd_cnt[c] = 0; wr_cnt[c] = 0; end
      end else begin
        for (int c = 0; c < 2; c++) begin
          if (rd_cnt[c] > 0) begin
            rd_cnt[c]--;
            if (rd_cnt[c] == 0) begin
              bus.mem_read_ready[c] = 1'b1;
              bus.mem_read_data[c]  = mem[rd_addr_p[c]];
            end
          end
          if (wr_cnt[c] > 0) begin
            wr_cnt[c]--;
            if (wr_cnt[c] == 0) begin
              bus.mem_write_ready[c] = 1'b1;
              mem[wr_addr_p[c]]      = wr_data_p[c];
            end
          end
          if (bus.mem_read_valid[c]) begin
            check("rd_no_dup_pulse", 32'(rd_cnt[c]), 0);
            rd_cnt[c] = mem_lat;
            rd_addr_p[c] = bus.mem_read_addr[c];
            rd_pulses++;
            last_rd_issue_cyc[c] = cyc;
          end
          if (bus.mem_write_valid[c]) begin
            check("wr_no_dup_pulse", 32'(wr_cnt[c]), 0);
            wr_cnt[c] = mem_lat;
            wr_addr_p[c] = bus.mem_write_addr[c];
            wr_data_p[c] = bus.mem_write_data[c];
            wr_pulses++;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every rising consumer ready consumes the next expected completion.
  initial begin : monitor
    logic [3:0] prr, pwr;
    exp_t e;
    int wk;
    prr = '0;
    pwr = '0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        if (bus.consumer_read_ready[k] && !prr[k]) begin
          rd_rise_cyc[k] = cyc;
          if (rd_exp.size() == 0) begin
            tests++; fails++;
            $display("FAIL rd_unexpected: consumer %0d got read ready, none expected", k);
          end else begin
            e = rd_exp.pop_front();
            check("rd_consumer_order", 32'(k), 32'(e.k));
            check("rd_data", 32'(bus.consumer_read_data[k]), 32'(e.d));
          end
        end
        if (bus.consumer_write_ready[k] && !pwr[k]) begin
          wr_rise_cyc[k] = cyc;
          if (wr_exp.size() == 0) begin
            tests++; fails++;
            $display("FAIL wr_unexpected: consumer %0d got write ready, none expected", k);
          end else begin
            wk = wr_exp.pop_front();
            check("wr_consumer_order", 32'(k), 32'(wk));
          end
        end
      end
      prr = bus.consumer_read_ready;
      pwr = bus.consumer_write_ready;
    end
  end

  task automatic do_read(input int k, input logic [7:0] a, input logic [7:0] d, input int hold);
    int n;
    bus.consumer_read_addr[k]  = a;
    bus.consumer_read_valid[k] = 1'b1;
    n = 0;
    while (bus.consumer_read_ready[k] !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) begin
      tests++; fails++;
      $display("FAIL rd_timeout: consumer %0d never saw read ready", k);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("slow_rd_ready_held", 32'(bus.consumer_read_ready[k]), 1);
      check("slow_rd_data_stable", 32'(bus.consumer_read_data[k]), 32'(d));
    end
    bus.consumer_read_valid[k] = 1'b0;
    @(posedge clk); #1;
    check("rd_ready_clear", 32'(bus.consumer_read_ready[k]), 0);
  endtask

  task automatic do_write(input int k, input logic [7:0] a, input logic [7:0] d);
    int n;
    bus.consumer_write_addr[k]  = a;
    bus.consumer_write_data[k]  = d;
    bus.consumer_write_valid[k] = 1'b1;
    n = 0;
    while (bus.consumer_write_ready[k] !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) begin
      tests++; fails++;
      $display("FAIL wr_timeout: consumer %0d never saw write ready", k);
    end
    bus.consumer_write_valid[k] = 1'b0;
    @(posedge clk); #1;
    check("wr_ready_clear", 32'(bus.consumer_write_ready[k]), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.consumer_read_valid  = '0;
    bus.consumer_write_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, p;
    reset = 1'b1;
    bus.consumer_read_valid = '0;  bus.consumer_read_addr = '0;
    bus.consumer_write_valid = '0; bus.consumer_write_addr = '0; bus.consumer_write_data = '0;
    bus2.consumer_read_valid = '0; bus2.consumer_read_addr = '0;
    bus2.consumer_write_valid = '0; bus2.consumer_write_addr = '0; bus2.consumer_write_data = '0;
    bus2.mem_read_ready = '0; bus2.mem_read_data = '0; bus2.mem_write_ready = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'hA5;

    repeat (3) @(posedge clk); #1;
    check("rst_mem_read_valid", 32'(bus.mem_read_valid), 0);
    check("rst_mem_write_valid", 32'(bus.mem_write_valid), 0);
    check("rst_consumer_read_ready", 32'(bus.consumer_read_ready), 0);
    check("rst_consumer_write_ready", 32'(bus.consumer_write_ready), 0);
    check("rst_consumer_read_data", 32'(bus.consumer_read_data), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single read, latency 2: issue in t0+1, memory ready t0+3, consumer ready t0+4.
    t0 = cyc;
    p  = rd_pulses;
    exp_rd(0, 8'hA5);
    do_read(0, 8'h10, 8'hA5, 0);
    check("single_issue_cycle_ch0", 32'(last_rd_issue_cyc[0]), 32'(t0 + 1));
    check("single_ready_cycle", 32'(rd_rise_cyc[0]), 32'(t0 + 4));
    check("single_pulse_count", 32'(rd_pulses - p), 1);

    // Contention: four readers, two channels, served 0,1,2,3.
    do_reset();
    p = rd_pulses;
    exp_rd(0, 8'h5B); exp_rd(1, 8'h58); exp_rd(2, 8'h59); exp_rd(3, 8'h5E);
    fork
      do_read(0, 8'h01, 8'h5B, 0);
      do_read(1, 8'h02, 8'h58, 0);
      do_read(2, 8'h03, 8'h59, 0);
      do_read(3, 8'h04, 8'h5E, 0);
    join
    check("contention_pulse_count", 32'(rd_pulses - p), 4);

    // Fairness: consumer 0 re-requests at once; 1-3 must be served before its second turn.
    do_reset();
    exp_rd(0, 8'hA5); exp_rd(1, 8'h4B); exp_rd(2, 8'h48); exp_rd(3, 8'h49);
    exp_rd(0, 8'hA5); exp_rd(0, 8'hA5);
    fork
      begin repeat (3) do_read(0, 8'h10, 8'hA5, 0); end
      do_read(1, 8'h11, 8'h4B, 0);
      do_read(2, 8'h12, 8'h48, 0);
      do_read(3, 8'h13, 8'h49, 0);
    join

    // Write then read-back.
    do_reset();
    wr_exp.push_back(2);
    do_write(2, 8'h20, 8'h3C);
    check("write_mem_content", 32'(mem[8'h20]), 32'h3C);
    exp_rd(2, 8'h3C);
    do_read(2, 8'h20, 8'h3C, 0);

    // Read and write raised together: read is served first, write afterwards.
    do_reset();
    exp_rd(3, 8'h5F);
    wr_exp.push_back(3);
    fork
      do_read(3, 8'h05, 8'h5F, 0);
      do_write(3, 8'h06, 8'h77);
    join
    check("read_before_write", 32'(rd_rise_cyc[3] < wr_rise_cyc[3]), 1);
    check("rw_write_mem_content", 32'(mem[8'h06]), 32'h77);

    // Slow consumer holds valid 5 cycles after ready.
    do_reset();
    p = rd_pulses;
    exp_rd(1, 8'h1A);
    do_read(1, 8'h40, 8'h1A, 5);
    check("slow_pulse_count", 32'(rd_pulses - p), 1);

    // Reset during RD_WAIT drops the transfer; a fresh read then completes.
    do_reset();
    mem_lat = 6;
    p = rd_pulses;
    bus.consumer_read_addr[1]  = 8'h30;
    bus.consumer_read_valid[1] = 1'b1;
    t0 = 0;
    while (rd_pulses == p && t0 < 50) begin @(posedge clk); #1; t0++; end
    check("midrst_issued", 32'(rd_pulses - p), 1);
    @(posedge clk); #1;
    check("midrst_addr_before", 32'(bus.mem_read_addr[0]), 32'h30);
    #2;
    reset = 1'b1;
    bus.consumer_read_valid[1] = 1'b0;
    #1;
    check("midrst_consumer_read_ready", 32'(bus.consumer_read_ready), 0);
    check("midrst_consumer_read_data", 32'(bus.consumer_read_data), 0);
    check("midrst_mem_read_valid", 32'(bus.mem_read_valid), 0);
    check("midrst_mem_read_addr", 32'(bus.mem_read_addr), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mem_lat = 2;
    @(posedge clk); #1;
    exp_rd(1, 8'h6A);
    do_read(1, 8'h30, 8'h6A, 0);

    // WRITE_ENABLE = 0 instance never issues or acknowledges writes.
    begin : no_write
      logic seen;
      seen = 1'b0;
      bus2.consumer_write_addr[0]  = 8'h20;
      bus2.consumer_write_data[0]  = 8'h3C;
      bus2.consumer_write_valid[0] = 1'b1;
      repeat (8) begin
        @(posedge clk); #1;
        seen = seen | (|bus2.mem_write_valid) | (|bus2.consumer_write_ready) | (|bus2.mem_read_valid);
      end
      check("nw_no_write_activity", 32'(seen), 0);
      check("nw_mem_write_data", 32'(bus2.mem_write_data), 0);
      bus2.consumer_write_valid[0] = 1'b0;
    end

    repeat (3) @(posedge clk); #1;
    check("sb_rd_drained", 32'(rd_exp.size()), 0);
    check("sb_wr_drained", 32'(wr_exp.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
